// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter
// ---------------------------------------------------------------------------
// Writeback arbiter for the single write port of the general-purpose
// register file. Two producers, the load unit (LD) and the ALU pipeline
// (ALU), each hand over results through a valid/ready handshake into a
// one-entry buffer. One buffered result per cycle is granted into a
// registered write stage that drives wbe/rdn/rdd. A pending-write mask
// lets decode detect hazards against buffered or staged writes.
//
// Optional feature (macro GPR_WB_RR_EN):
//   defined   - round-robin arbitration with a 1-bit pointer that flips
//               only after a contended grant
//   undefined - fixed priority, LD always beats ALU (no pointer flop)
//
// Ports:
//   clk        - clock, all state updates on posedge
//   rstn       - asynchronous active-low reset
//   flush      - synchronous discard of buffered and staged writes
//   ld_valid / ld_rdn / ld_rdd / ld_ready     - LD producer handshake
//   alu_valid / alu_rdn / alu_rdd / alu_ready - ALU producer handshake
//   wbe / rdn / rdd - registered register-file write port
//   pend_mask  - bit r set while a write to xr is buffered or staged
// ---------------------------------------------------------------------------
module gpr_wb_arbiter #(
    parameter int WordSize = 32
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                flush,
    input  logic                ld_valid,
    input  logic [4:0]          ld_rdn,
    input  logic [WordSize-1:0] ld_rdd,
    output logic                ld_ready,
    input  logic                alu_valid,
    input  logic [4:0]          alu_rdn,
    input  logic [WordSize-1:0] alu_rdd,
    output logic                alu_ready,
    output logic                wbe,
    output logic [4:0]          rdn,
    output logic [WordSize-1:0] rdd,
    output logic [31:0]         pend_mask
);

    // One-hot decode of a register index, gated by an enable.
    function automatic logic [31:0] onehot_reg(input logic en, input logic [4:0] idx);
        return {31'd0, en} << idx;
    endfunction

    // Per-port buffer state
    logic                ld_bv_q,   ld_bv_d;
    logic [4:0]          ld_brdn_q, ld_brdn_d;
    logic [WordSize-1:0] ld_brdd_q, ld_brdd_d;
    logic                alu_bv_q,   alu_bv_d;
    logic [4:0]          alu_brdn_q, alu_brdn_d;
    logic [WordSize-1:0] alu_brdd_q, alu_brdd_d;

    // Write stage state
    logic                wbe_q, wbe_d;
    logic [4:0]          rdn_q, rdn_d;
    logic [WordSize-1:0] rdd_q, rdd_d;

    logic ld_prio_s;
    logic grant_ld_s;
    logic grant_alu_s;
    logic ld_xfer_s;
    logic alu_xfer_s;
    logic contended_s;

    assign contended_s = ld_bv_q && alu_bv_q;

`ifdef GPR_WB_RR_EN
    // Pointer value 0 gives LD priority, 1 gives ALU priority.
    logic ptr_q, ptr_d;

    assign ld_prio_s = !ptr_q;

    // Pointer moves to the losing port only after a contended grant.
    always_comb begin
        ptr_d = ptr_q;
        if (contended_s && grant_ld_s) begin
            ptr_d = 1'b1;
        end else if (contended_s && grant_alu_s) begin
            ptr_d = 1'b0;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign ld_prio_s = 1'b1;
`endif

    // Grant selection over buffered entries only; flush blocks all grants.
    always_comb begin
        grant_ld_s  = 1'b0;
        grant_alu_s = 1'b0;
        if (flush) begin
            grant_ld_s  = 1'b0;
            grant_alu_s = 1'b0;
        end else if (contended_s) begin
            grant_ld_s  = ld_prio_s;
            grant_alu_s = !ld_prio_s;
        end else begin
            grant_ld_s  = ld_bv_q;
            grant_alu_s = alu_bv_q;
        end
    end

    // A port can accept when its buffer is empty or is being drained now.
    assign ld_ready   = !flush && (!ld_bv_q || grant_ld_s);
    assign alu_ready  = !flush && (!alu_bv_q || grant_alu_s);
    assign ld_xfer_s  = ld_valid && ld_ready;
    assign alu_xfer_s = alu_valid && alu_ready;

    // LD buffer next state: a transfer overrides a simultaneous grant.
    always_comb begin
        ld_bv_d   = ld_bv_q;
        ld_brdn_d = ld_brdn_q;
        ld_brdd_d = ld_brdd_q;
        if (flush) begin
            ld_bv_d = 1'b0;
        end else if (ld_xfer_s) begin
            ld_bv_d   = 1'b1;
            ld_brdn_d = ld_rdn;
            ld_brdd_d = ld_rdd;
        end else if (grant_ld_s) begin
            ld_bv_d = 1'b0;
        end else begin
            ld_bv_d = ld_bv_q;
        end
    end

    // ALU buffer next state: a transfer overrides a simultaneous grant.
    always_comb begin
        alu_bv_d   = alu_bv_q;
        alu_brdn_d = alu_brdn_q;
        alu_brdd_d = alu_brdd_q;
        if (flush) begin
            alu_bv_d = 1'b0;
        end else if (alu_xfer_s) begin
            alu_bv_d   = 1'b1;
            alu_brdn_d = alu_rdn;
            alu_brdd_d = alu_rdd;
        end else if (grant_alu_s) begin
            alu_bv_d = 1'b0;
        end else begin
            alu_bv_d = alu_bv_q;
        end
    end

    // Write stage next state: x0 is granted but never enables the write;
    // rdn/rdd hold when nothing is granted.
    always_comb begin
        wbe_d = 1'b0;
        rdn_d = rdn_q;
        rdd_d = rdd_q;
        if (grant_ld_s) begin
            wbe_d = (ld_brdn_q != 5'd0);
            rdn_d = ld_brdn_q;
            rdd_d = ld_brdd_q;
        end else if (grant_alu_s) begin
            wbe_d = (alu_brdn_q != 5'd0);
            rdn_d = alu_brdn_q;
            rdd_d = alu_brdd_q;
        end else begin
            wbe_d = 1'b0;
        end
    end

    // Buffer and write stage registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ld_bv_q    <= 1'b0;
            ld_brdn_q  <= 5'd0;
            ld_brdd_q  <= '0;
            alu_bv_q   <= 1'b0;
            alu_brdn_q <= 5'd0;
            alu_brdd_q <= '0;
            wbe_q      <= 1'b0;
            rdn_q      <= 5'd0;
            rdd_q      <= '0;
        end else begin
            ld_bv_q    <= ld_bv_d;
            ld_brdn_q  <= ld_brdn_d;
            ld_brdd_q  <= ld_brdd_d;
            alu_bv_q   <= alu_bv_d;
            alu_brdn_q <= alu_brdn_d;
            alu_brdd_q <= alu_brdd_d;
            wbe_q      <= wbe_d;
            rdn_q      <= rdn_d;
            rdd_q      <= rdd_d;
        end
    end

    assign wbe = wbe_q;
    assign rdn = rdn_q;
    assign rdd = rdd_q;

    // Bit 0 is masked off: x0 writes are never a hazard.
    assign pend_mask = (onehot_reg(ld_bv_q, ld_brdn_q)
                      | onehot_reg(alu_bv_q, alu_brdn_q)
                      | onehot_reg(wbe_q, rdn_q)) & ~32'd1;

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
module tb_gpr_wb_arbiter;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         flush = 1'b0;
    logic         ld_valid = 1'b0;
    logic [4:0]   ld_rdn = 5'd0;
    logic [W-1:0] ld_rdd = 32'd0;
    logic         ld_ready;
    logic         alu_valid = 1'b0;
    logic [4:0]   alu_rdn = 5'd0;
    logic [W-1:0] alu_rdd = 32'd0;
    logic         alu_ready;
    logic         wbe;
    logic [4:0]   rdn;
    logic [W-1:0] rdd;
    logic [31:0]  pend_mask;

    always #5 clk = ~clk;

    gpr_wb_arbiter #(.WordSize(W)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .ld_valid(ld_valid), .ld_rdn(ld_rdn), .ld_rdd(ld_rdd), .ld_ready(ld_ready),
        .alu_valid(alu_valid), .alu_rdn(alu_rdn), .alu_rdd(alu_rdd), .alu_ready(alu_ready),
        .wbe(wbe), .rdn(rdn), .rdd(rdd), .pend_mask(pend_mask)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic fl, input logic lv, input logic [4:0] lr, input logic [31:0] ldat,
                         input logic av, input logic [4:0] ar, input logic [31:0] adat);
        flush = fl; ld_valid = lv; ld_rdn = lr; ld_rdd = ldat;
        alu_valid = av; alu_rdn = ar; alu_rdd = adat;
    endtask

    task automatic chk_out(input string tag, input logic ew, input logic [4:0] er,
                           input logic [31:0] ed, input logic [31:0] em);
        chk({tag, ".wbe"}, 64'(wbe), 64'(ew));
        chk({tag, ".rdn"}, 64'(rdn), 64'(er));
        chk({tag, ".rdd"}, 64'(rdd), 64'(ed));
        chk({tag, ".pend"}, 64'(pend_mask), 64'(em));
    endtask

    // Directed vectors: inputs for one cycle, readies expected before the
    // edge, registered outputs expected after it.
    typedef struct {
        logic fl; logic lv; logic [4:0] lr; logic [31:0] ld;
        logic av; logic [4:0] ar; logic [31:0] ad;
        logic e_ldr; logic e_alr; logic e_wbe; logic [4:0] e_rdn; logic [31:0] e_rdd; logic [31:0] e_pm;
    } vec_t;
    vec_t vt[15];

    // Behavioural reference: each port is a queue of at most one result.
    typedef struct { logic [4:0] rn; logic [31:0] rd; } ent_t;
    ent_t mq_ld[$];
    ent_t mq_alu[$];
    bit           m_ld_first;
    logic         m_wbe;
    logic [4:0]   m_rdn;
    logic [31:0]  m_rdd;

    function automatic logic [31:0] model_mask();
        logic [31:0] m = 32'd0;
        foreach (mq_ld[i]) if (mq_ld[i].rn != 5'd0) m[mq_ld[i].rn] = 1'b1;
        foreach (mq_alu[i]) if (mq_alu[i].rn != 5'd0) m[mq_alu[i].rn] = 1'b1;
        if (m_wbe && m_rdn != 5'd0) m[m_rdn] = 1'b1;
        return m;
    endfunction

    task automatic model_reset();
        mq_ld.delete(); mq_alu.delete();
        m_ld_first = 1'b1; m_wbe = 1'b0; m_rdn = 5'd0; m_rdd = 32'd0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic h_ld, h_alu;
        string tag;

        vt[0]  = '{0,0,0,0,0,0,0,                               1,1,0,0,0,0};
        vt[1]  = '{0,0,0,0,1,5,32'hDEADBEEF,                    1,1,0,0,0,32'h20};
        vt[2]  = '{0,0,0,0,0,0,0,                               1,1,1,5,32'hDEADBEEF,32'h20};
        vt[3]  = '{0,0,0,0,0,0,0,                               1,1,0,5,32'hDEADBEEF,0};
        vt[4]  = '{0,1,3,32'h11,1,4,32'h22,                     1,1,0,5,32'hDEADBEEF,32'h18};
        vt[5]  = '{0,0,0,0,0,0,0,                               1,0,1,3,32'h11,32'h18};
        vt[6]  = '{0,0,0,0,0,0,0,                               1,1,1,4,32'h22,32'h10};
        vt[7]  = '{0,0,0,0,0,0,0,                               1,1,0,4,32'h22,0};
        vt[8]  = '{0,1,0,32'hFFFFFFFF,0,0,0,                    1,1,0,4,32'h22,0};
        vt[9]  = '{0,0,0,0,0,0,0,                               1,1,0,0,32'hFFFFFFFF,0};
        vt[10] = '{0,0,0,0,0,0,0,                               1,1,0,0,32'hFFFFFFFF,0};
        vt[11] = '{0,1,7,32'h77,1,9,32'h99,                     1,1,0,0,32'hFFFFFFFF,32'h280};
        vt[12] = '{1,1,12,32'hC,1,13,32'hD,                     0,0,0,0,32'hFFFFFFFF,0};
        vt[13] = '{0,0,0,0,0,0,0,                               1,1,0,0,32'hFFFFFFFF,0};
        vt[14] = '{0,0,0,0,0,0,0,                               1,1,0,0,32'hFFFFFFFF,0};

        // Reset with random inputs applied
        rstn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
            @(posedge clk); #1;
            chk_out("reset", 1'b0, 5'd0, 32'd0, 32'd0);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("idle.ld_ready", 64'(ld_ready), 64'd1);
        chk("idle.alu_ready", 64'(alu_ready), 64'd1);
        chk_out("idle", 1'b0, 5'd0, 32'd0, 32'd0);

        // Directed table
        for (int i = 0; i < 15; i++) begin
            drive(vt[i].fl, vt[i].lv, vt[i].lr, vt[i].ld, vt[i].av, vt[i].ar, vt[i].ad);
            #1;
            tag = $sformatf("vec%0d", i);
            chk({tag, ".ld_ready"}, 64'(ld_ready), 64'(vt[i].e_ldr));
            chk({tag, ".alu_ready"}, 64'(alu_ready), 64'(vt[i].e_alr));
            @(posedge clk); #1;
            chk_out(tag, vt[i].e_wbe, vt[i].e_rdn, vt[i].e_rdd, vt[i].e_pm);
        end

        // Back-to-back LD stream x1..x8
        for (int i = 0; i < 10; i++) begin
            if (i < 8) drive(0, 1, 5'(i + 1), 32'h100 + 32'(i + 1), 0, 0, 0);
            else       drive(0, 0, 0, 0, 0, 0, 0);
            #1;
            if (i < 8) chk($sformatf("stream%0d.ld_ready", i), 64'(ld_ready), 64'd1);
            @(posedge clk); #1;
            chk($sformatf("stream%0d.wbe", i), 64'(wbe), 64'((i >= 1) && (i <= 8)));
            if (i >= 1 && i <= 8) begin
                chk($sformatf("stream%0d.rdn", i), 64'(rdn), 64'(i));
                chk($sformatf("stream%0d.rdd", i), 64'(rdd), 64'(32'h100 + 32'(i)));
            end
        end

        // Reset asserted with both buffers full: all state is lost at once
        drive(0, 1, 10, 32'hA0, 1, 11, 32'hB0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("midrst.pend_before", 64'(pend_mask), 64'(32'h0C00));
        rstn = 1'b0;
        #1;
        chk_out("midrst", 1'b0, 5'd0, 32'd0, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk_out($sformatf("midrst_after%0d", i), 1'b0, 5'd0, 32'd0, 32'd0);
        end

        // Randomized traffic against the reference model
        rstn = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        h_ld = 1'b0; h_alu = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            int  win;
            bit  e_ldr, e_alr, both;
            ent_t e;
            if (!h_ld) begin
                ld_valid = ($urandom_range(0, 99) < 60);
                ld_rdn   = 5'($urandom_range(0, 31));
                ld_rdd   = $urandom;
            end
            if (!h_alu) begin
                alu_valid = ($urandom_range(0, 99) < 60);
                alu_rdn   = 5'($urandom_range(0, 31));
                alu_rdd   = $urandom;
            end
            flush = ($urandom_range(0, 19) == 0);
            #1;
            win  = -1;
            both = (mq_ld.size() != 0) && (mq_alu.size() != 0);
            if (!flush) begin
`ifdef GPR_WB_RR_EN
                if (both) win = m_ld_first ? 0 : 1;
`else
                if (both) win = 0;
`endif
                else if (mq_ld.size() != 0) win = 0;
                else if (mq_alu.size() != 0) win = 1;
            end
            e_ldr = !flush && (mq_ld.size() == 0 || win == 0);
            e_alr = !flush && (mq_alu.size() == 0 || win == 1);
            chk("rnd.ld_ready", 64'(ld_ready), 64'(e_ldr));
            chk("rnd.alu_ready", 64'(alu_ready), 64'(e_alr));
            if (flush) begin
                mq_ld.delete(); mq_alu.delete();
                m_wbe = 1'b0;
            end else if (win >= 0) begin
                e = (win == 0) ? mq_ld.pop_front() : mq_alu.pop_front();
                m_wbe = (e.rn != 5'd0);
                m_rdn = e.rn;
                m_rdd = e.rd;
`ifdef GPR_WB_RR_EN
                if (both) m_ld_first = (win == 1);
`endif
            end else begin
                m_wbe = 1'b0;
            end
            if (ld_valid && e_ldr) mq_ld.push_back('{ld_rdn, ld_rdd});
            if (alu_valid && e_alr) mq_alu.push_back('{alu_rdn, alu_rdd});
            h_ld  = ld_valid && !e_ldr;
            h_alu = alu_valid && !e_alr;
            @(posedge clk); #1;
            chk_out("rnd", m_wbe, m_rdn, m_rdd, model_mask());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/gpr_wb_arbiter.md
# gpr_wb_arbiter

Writeback arbiter for the general-purpose register file's single write port. It accepts completed results from two producers, the load unit (port LD) and the ALU pipeline (port ALU), through valid/ready handshakes. Each port buffers one result, and the block grants one buffered result per cycle to a registered write stage that drives the register file's `wbe`/`rdn`/`rdd` inputs. It also publishes a pending-write mask for hazard detection in decode.

## Interface
Parameters:
- `WordSize`, default 32: data width of results and of `rdd`.

Ports:
- `clk`, input, 1: single clock. All state updates on posedge.
- `rstn`, input, 1: asynchronous active-low reset.
- `flush`, input, 1: synchronous discard of all buffered and staged writes.
- `ld_valid`, input, 1: load result offered.
- `ld_rdn`, input, 5: load destination register.
- `ld_rdd`, input, WordSize: load result data.
- `ld_ready`, output, 1: LD buffer can take a result this cycle.
- `alu_valid`, input, 1: ALU result offered.
- `alu_rdn`, input, 5: ALU destination register.
- `alu_rdd`, input, WordSize: ALU result data.
- `alu_ready`, output, 1: ALU buffer can take a result this cycle.
- `wbe`, output, 1: register file write enable (registered).
- `rdn`, output, 5: register file write index (registered).
- `rdd`, output, WordSize: register file write data (registered).
- `pend_mask`, output, 32: bit r is set while a write to register r is buffered or staged. Bit 0 is always 0.

## Operation
- Handshake: a transfer occurs on a posedge where `X_valid && X_ready`. The producer holds `X_rdn`/`X_rdd` stable while `X_valid && !X_ready`.
- Per-port buffer: one entry holding `bv`, `brdn` and `brdd`. The entry loads on transfer and clears when granted without a simultaneous transfer.
- Ready: `X_ready = !flush && (!bv_X || grant_X)`. It is combinational and allows full throughput on one port.
- Arbitration: combinational over the buffered entries only. Offered but unbuffered inputs are not eligible.
  - If only one buffer is valid, that port is granted.
  - If both buffers are valid, the winner is chosen per Configuration.
- Write stage: on each posedge, `wbe <= grant_any && (granted brdn != 0)`, `rdn <= granted brdn` and `rdd <= granted brdd`.
  - If nothing is granted, `wbe <= 0`, and `rdn`/`rdd` hold their values.
- Register x0:
  - Writes to x0 are accepted and granted normally but never assert `wbe`.
  - x0 never sets `pend_mask`.
- `pend_mask` is the OR of the one-hot decode of each valid buffer's `brdn` and of `rdn` while `wbe` is high. It is combinational from registered state.
- Flush:
  - On a posedge with `flush` high, both `bv` are cleared and `wbe <= 0`.
  - No grants or transfers happen in the flush cycle; both readies are 0.
  - The pointer is unchanged.
- Same `rdn` in both buffers: both writes are issued in grant order, and the later grant wins in the register file. Producers own ordering; the block does not merge or reorder within a port.

## Timing
- Reset values: `wbe`=0, `rdn`=0, `rdd`=0, both `bv`=0, RR pointer=LD priority, `pend_mask`=0. The readies are 1 once `rstn` is high.
- Latency:
  - A transfer at edge N with the port uncontended is granted in the cycle after N.
  - `wbe` is high in the cycle after edge N+1, i.e. 2 edges from handshake to register-file write.
- Throughput: 1 write per cycle in aggregate. A single port sustains 1 per cycle. Under contention each port gets 1 per 2 cycles in RR mode.
- Simultaneous transfer and grant on one port: the buffer reloads with the new result and `bv` stays 1.
- Reset asserted mid-operation: all state clears immediately, and buffered results are lost.

## Configuration
- `GPR_WB_RR_EN` defined:
  - Round-robin arbitration, with a 1-bit pointer.
  - After a contended grant, the pointer points to the other port. Uncontended grants do not move it.
- Not defined:
  - Fixed priority: LD always beats ALU.
  - No pointer flop exists. ALU can starve under continuous LD traffic.

## Test plan
- Reset and idle: assert `rstn`=0 with inputs random, release with no traffic -> `wbe`=0, `pend_mask`=0, `ld_ready`=`alu_ready`=1.
- Single write: ALU `rdn`=5, `rdd`=0xDEADBEEF handshake at edge N -> `pend_mask`[5]=1 during cycles N+1 and N+2; `wbe`=1, `rdn`=5, `rdd`=0xDEADBEEF in cycle N+2.
- Contention: both ports handshake at edge N (LD x3=0x11, ALU x4=0x22) and stay quiet afterwards.
  - RR build: `wbe` for x3 in cycle N+2, then x4 in cycle N+3.
  - Fixed build: same order, and `alu_ready`=0 in cycle N+1.
- Back-to-back single port: LD streams x1..x8 on consecutive edges -> `ld_ready` stays 1 and `wbe` is 1 for 8 consecutive cycles with `rdn` 1..8.
- x0 write: LD `rdn`=0, `rdd`=0xFFFFFFFF -> handshake completes, `wbe` stays 0, `pend_mask`=0 throughout.
- Flush: both buffers valid (x7, x9) and `flush`=1 for one cycle -> next cycle `wbe`=0, `pend_mask`=0, and neither write ever appears. Both readies are 0 during the flush cycle.
